// File: rtl/countdown_pkg.sv
// Shared definitions for the MM:SS BCD countdown timer.
//   - state_t    : controller state encoding
//   - BCD_W      : width of one BCD digit
//   - UNITS_MAX  : largest value of a units digit (sec/min units)
//   - TENS_MAX   : largest value of a tens digit (sec/min tens)
//   - clamp_bcd  : saturates a preset digit to its legal maximum
package countdown_pkg;

    localparam int unsigned BCD_W     = 4;
    localparam int unsigned UNITS_MAX = 9;
    localparam int unsigned TENS_MAX  = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        ALARM  = 2'd3
    } state_t;

    function automatic logic [BCD_W-1:0] clamp_bcd(input logic [BCD_W-1:0] val,
                                                   input logic [BCD_W-1:0] max);
        return (val > max) ? max : val;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit of the countdown timer.
// Ports:
//   clk        : system clock
//   rst        : synchronous active-high reset, clears the digit to 0
//   dec        : decrement this digit on the current edge
//   load       : load load_val (takes priority over dec)
//   load_val   : preset value, already clamped to MAX by the caller
//   out        : current digit value
//   borrow_out : dec while the digit is 0, i.e. it wraps to MAX and borrows
module bcd_down_digit
    import countdown_pkg::*;
#(
    parameter int unsigned MAX = UNITS_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    output logic [BCD_W-1:0] out,
    output logic             borrow_out
);

    localparam logic [BCD_W-1:0] MaxVal = BCD_W'(MAX);

    assign borrow_out = dec && (out == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
        end else if (load) begin
            out <= load_val;
        end else if (dec) begin
            out <= (out == '0) ? MaxVal : out - BCD_W'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with load/start/pause control and expiry alarm.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   en                       : 1 Hz tick, one clk wide
//   start, pause, load       : debounced single-cycle control pulses
//   load_dig_1..4            : BCD preset (sec units, sec tens, min units, min tens)
//   dig_1_out..dig_4_out     : current time in the same digit order
//   dig_upd                  : bit i set when digit i+1 changed by a decrement this cycle
//   running, done, alarm     : in RUN, expiry pulse, in ALARM
// Build option: define COUNTDOWN_AUTORELOAD_EN to reload the last preset at expiry and keep
// running instead of entering ALARM.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int unsigned ALARM_TICKS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       start,
    input  logic       pause,
    input  logic       load,
    input  logic [3:0] load_dig_1,
    input  logic [3:0] load_dig_2,
    input  logic [3:0] load_dig_3,
    input  logic [3:0] load_dig_4,
    output logic [3:0] dig_1_out,
    output logic [3:0] dig_2_out,
    output logic [3:0] dig_3_out,
    output logic [3:0] dig_4_out,
    output logic [3:0] dig_upd,
    output logic       running,
    output logic       done,
    output logic       alarm
);

    localparam logic [3:0] UnitsMax  = BCD_W'(UNITS_MAX);
    localparam logic [3:0] TensMax   = BCD_W'(TENS_MAX);
    localparam logic [3:0] AlarmLast = 4'(ALARM_TICKS - 1);

    state_t     state;
    logic [3:0] alarm_cnt;

    logic       load_acc, pause_acc, start_acc, dec, expire, time_zero;
    logic [3:0] b;  // borrow out of each digit
    logic [3:0] clamp_1, clamp_2, clamp_3, clamp_4;
    logic [3:0] val_1, val_2, val_3, val_4;
    logic       dig_load;

    assign clamp_1 = clamp_bcd(load_dig_1, UnitsMax);
    assign clamp_2 = clamp_bcd(load_dig_2, TensMax);
    assign clamp_3 = clamp_bcd(load_dig_3, UnitsMax);
    assign clamp_4 = clamp_bcd(load_dig_4, TensMax);

    assign time_zero = (dig_1_out == 4'd0) && (dig_2_out == 4'd0) &&
                       (dig_3_out == 4'd0) && (dig_4_out == 4'd0);

    // load is never accepted in RUN, so it cannot collide with pause or a decrement.
    assign load_acc  = load && (state != RUN);
    assign pause_acc = pause && (state == RUN);
    assign start_acc = start && !load_acc && (state != RUN);
    assign dec       = en && (state == RUN) && !pause_acc;
    // Only 00:01 decrements to 00:00, so this is the single expiry point.
    assign expire    = dec && (dig_1_out == 4'd1) && (dig_2_out == 4'd0) &&
                       (dig_3_out == 4'd0) && (dig_4_out == 4'd0);

`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [3:0] rl_1, rl_2, rl_3, rl_4;
    logic       rl_zero;

    assign rl_zero  = (rl_1 == 4'd0) && (rl_2 == 4'd0) && (rl_3 == 4'd0) && (rl_4 == 4'd0);
    assign dig_load = load_acc || expire;
    assign val_1    = load_acc ? clamp_1 : rl_1;
    assign val_2    = load_acc ? clamp_2 : rl_2;
    assign val_3    = load_acc ? clamp_3 : rl_3;
    assign val_4    = load_acc ? clamp_4 : rl_4;

    always_ff @(posedge clk) begin
        if (rst) begin
            rl_1 <= 4'd0;
            rl_2 <= 4'd0;
            rl_3 <= 4'd0;
            rl_4 <= 4'd0;
        end else if (load_acc) begin
            rl_1 <= clamp_1;
            rl_2 <= clamp_2;
            rl_3 <= clamp_3;
            rl_4 <= clamp_4;
        end
    end
`else
    assign dig_load = load_acc;
    assign val_1    = clamp_1;
    assign val_2    = clamp_2;
    assign val_3    = clamp_3;
    assign val_4    = clamp_4;
`endif

    bcd_down_digit #(.MAX(UNITS_MAX)) u_dig_1 (
        .clk        (clk),
        .rst        (rst),
        .dec        (dec),
        .load       (dig_load),
        .load_val   (val_1),
        .out        (dig_1_out),
        .borrow_out (b[0])
    );

    bcd_down_digit #(.MAX(TENS_MAX)) u_dig_2 (
        .clk        (clk),
        .rst        (rst),
        .dec        (b[0]),
        .load       (dig_load),
        .load_val   (val_2),
        .out        (dig_2_out),
        .borrow_out (b[1])
    );

    bcd_down_digit #(.MAX(UNITS_MAX)) u_dig_3 (
        .clk        (clk),
        .rst        (rst),
        .dec        (b[1]),
        .load       (dig_load),
        .load_val   (val_3),
        .out        (dig_3_out),
        .borrow_out (b[2])
    );

    bcd_down_digit #(.MAX(TENS_MAX)) u_dig_4 (
        .clk        (clk),
        .rst        (rst),
        .dec        (b[2]),
        .load       (dig_load),
        .load_val   (val_4),
        .out        (dig_4_out),
        .borrow_out (b[3])
    );

    assign running = (state == RUN);
    assign alarm   = (state == ALARM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            alarm_cnt <= 4'd0;
            dig_upd   <= 4'b0000;
            done      <= 1'b0;
        end else begin
            done    <= expire;
            dig_upd <= dec ? {b[2:0], 1'b1} : 4'b0000;

            if (load_acc) begin
                if (state == ALARM) begin
                    state <= IDLE;
                end
                alarm_cnt <= 4'd0;
            end else if (pause_acc) begin
                state <= PAUSED;
            end else if (start_acc) begin
                if (state == ALARM) begin
                    state     <= IDLE;
                    alarm_cnt <= 4'd0;
                end else if (!time_zero) begin
                    state <= RUN;
                end
            end else if (expire) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
                state <= rl_zero ? IDLE : RUN;
`else
                state <= ALARM;
`endif
                alarm_cnt <= 4'd0;
            end else if ((state == ALARM) && en) begin
                if (alarm_cnt >= AlarmLast) begin
                    state     <= IDLE;
                    alarm_cnt <= 4'd0;
                end else begin
                    alarm_cnt <= alarm_cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0, en = 1'b0, start = 1'b0, pause = 1'b0, load = 1'b0;
    logic [3:0] load_dig_1 = '0, load_dig_2 = '0, load_dig_3 = '0, load_dig_4 = '0;
    logic [3:0] dig_1_out, dig_2_out, dig_3_out, dig_4_out, dig_upd;
    logic       running, done, alarm;

    countdown_timer #(.ALARM_TICKS(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .start      (start),
        .pause      (pause),
        .load       (load),
        .load_dig_1 (load_dig_1),
        .load_dig_2 (load_dig_2),
        .load_dig_3 (load_dig_3),
        .load_dig_4 (load_dig_4),
        .dig_1_out  (dig_1_out),
        .dig_2_out  (dig_2_out),
        .dig_3_out  (dig_3_out),
        .dig_4_out  (dig_4_out),
        .dig_upd    (dig_upd),
        .running    (running),
        .done       (done),
        .alarm      (alarm)
    );

    always #5 clk = ~clk;

    // Packed observation: {d4,d3,d2,d1 (16), dig_upd (4), running, done, alarm}
    typedef struct {
        string       name;
        logic [22:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [22:0] obs[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [22:0] mk(input logic [15:0] t, input logic [3:0] u,
                                       input logic r, input logic d, input logic a);
        return {t, u, r, d, a};
    endfunction

    function automatic logic [22:0] snap();
        return {dig_4_out, dig_3_out, dig_2_out, dig_1_out, dig_upd, running, done, alarm};
    endfunction

    task automatic set_ld(input logic [3:0] d4, input logic [3:0] d3,
                          input logic [3:0] d2, input logic [3:0] d1);
        load_dig_4 = d4;
        load_dig_3 = d3;
        load_dig_2 = d2;
        load_dig_1 = d1;
    endtask

    // Drive one cycle of inputs, queue the expected result, capture the DUT result.
    task automatic cyc(input logic r, input logic e, input logic s, input logic p,
                       input logic l, input string name, input logic [22:0] x);
        exp_t item;
        item.name = name;
        item.val  = x;
        sb.push_back(item);
        rst = r; en = e; start = s; pause = p; load = l;
        @(posedge clk);
        #1;
        obs.push_back(snap());
        rst = 0; en = 0; start = 0; pause = 0; load = 0;
    endtask

    task automatic test_reset();
        exp_t        e;
        logic [22:0] o;
        set_ld(4'd1, 4'd2, 4'd3, 4'd4);
        cyc(0, 0, 0, 0, 1, "pre_reset_load", mk(16'h1234, 4'b0000, 0, 0, 0));
        cyc(0, 0, 1, 0, 0, "pre_reset_start", mk(16'h1234, 4'b0000, 1, 0, 0));
        cyc(1, 1, 0, 0, 0, "reset_state", mk(16'h0000, 4'b0000, 0, 0, 0));
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_checks++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL %s: got t=%h upd=%b r/d/a=%b want t=%h upd=%b r/d/a=%b",
                         e.name, o[22:7], o[6:3], o[2:0], e.val[22:7], e.val[6:3], e.val[2:0]);
            end
        end
    endtask

    task automatic test_units_borrow();
        exp_t        e;
        logic [22:0] o;
        cyc(1, 0, 0, 0, 0, "ub_rst", mk(16'h0000, 4'b0000, 0, 0, 0));
        set_ld(4'd0, 4'd1, 4'd3, 4'd0);
        cyc(0, 0, 0, 0, 1, "ub_load", mk(16'h0130, 4'b0000, 0, 0, 0));
        cyc(0, 0, 1, 0, 0, "ub_start", mk(16'h0130, 4'b0000, 1, 0, 0));
        cyc(0, 1, 0, 0, 0, "ub_dec", mk(16'h0129, 4'b0011, 1, 0, 0));
        cyc(0, 0, 0, 0, 0, "ub_idle_upd", mk(16'h0129, 4'b0000, 1, 0, 0));
        cyc(1, 0, 0, 0, 0, "bb_rst", mk(16'h0000, 4'b0000, 0, 0, 0));
        set_ld(4'd1, 4'd0, 4'd0, 4'd0);
        cyc(0, 0, 0, 0, 1, "bb_load", mk(16'h1000, 4'b0000, 0, 0, 0));
        cyc(0, 0, 1, 0, 0, "bb_start", mk(16'h1000, 4'b0000, 1, 0, 0));
        cyc(0, 1, 0, 0, 0, "bb_dec_all", mk(16'h0959, 4'b1111, 1, 0, 0));
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_checks++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL %s: got t=%h upd=%b r/d/a=%b want t=%h upd=%b r/d/a=%b",
                         e.name, o[22:7], o[6:3], o[2:0], e.val[22:7], e.val[6:3], e.val[2:0]);
            end
        end
    endtask

`ifndef COUNTDOWN_AUTORELOAD_EN
    task automatic test_expiry();
        exp_t        e;
        logic [22:0] o;
        cyc(1, 0, 0, 0, 0, "ex_rst", mk(16'h0000, 4'b0000, 0, 0, 0));
        set_ld(4'd0, 4'd0, 4'd0, 4'd2);
        cyc(0, 0, 0, 0, 1, "ex_load", mk(16'h0002, 4'b0000, 0, 0, 0));
        cyc(0, 0, 1, 0, 0, "ex_start", mk(16'h0002, 4'b0000, 1, 0, 0));
        cyc(0, 1, 0, 0, 0, "ex_dec1", mk(16'h0001, 4'b0001, 1, 0, 0));
        cyc(0, 1, 0, 0, 0, "ex_done", mk(16'h0000, 4'b0001, 0, 1, 1));
        cyc(0, 0, 0, 0, 0, "ex_done_fall", mk(16'h0000, 4'b0000, 0, 0, 1));
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 0, 0, "ex_alarm_hold", mk(16'h0000, 4'b0000, 0, 0, 1));
        end
        cyc(0, 1, 0, 0, 0, "ex_alarm_end", mk(16'h0000, 4'b0000, 0, 0, 0));
        cyc(0, 1, 0, 0, 0, "ex_no_wrap", mk(16'h0000, 4'b0000, 0, 0, 0));
        // Acknowledge with start, then leave ALARM through a load.
        set_ld(4'd0, 4'd0, 4'd0, 4'd1);
        cyc(0, 0, 0, 0, 1, "ack_load", mk(16'h0001, 4'b0000, 0, 0, 0));
        cyc(0, 0, 1, 0, 0, "ack_start", mk(16'h0001, 4'b0000, 1, 0, 0));
        cyc(0, 1, 0, 0, 0, "ack_expire", mk(16'h0000, 4'b0001, 0, 1, 1));
        cyc(0, 0, 1, 0, 0, "ack_start_idle", mk(16'h0000, 4'b0000, 0, 0, 0));
        cyc(0, 0, 1, 0, 0, "ack_start_zero", mk(16'h0000, 4'b0000, 0, 0, 0));
        cyc(0, 0, 0, 0, 1, "ack2_load", mk(16'h0001, 4'b0000, 0, 0, 0));
        cyc(0, 0, 1, 0, 0, "ack2_start", mk(16'h0001, 4'b0000, 1, 0, 0));
        cyc(0, 1, 0, 0, 0, "ack2_expire", mk(16'h0000, 4'b0001, 0, 1, 1));
        set_ld(4'd0, 4'd2, 4'd0, 4'd0);
        cyc(0, 0, 0, 0, 1, "alarm_load", mk(16'h0200, 4'b0000, 0, 0, 0));
        cyc(0, 1, 0, 0, 0, "alarm_load_idle", mk(16'h0200, 4'b0000, 0, 0, 0));
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_checks++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL %s: got t=%h upd=%b r/d/a=%b want t=%h upd=%b r/d/a=%b",
                         e.name, o[22:7], o[6:3], o[2:0], e.val[22:7], e.val[6:3], e.val[2:0]);
            end
        end
    endtask
`else
    task automatic test_autoreload();
        exp_t        e;
        logic [22:0] o;
        cyc(1, 0, 0, 0, 0, "ar_rst", mk(16'h0000, 4'b0000, 0, 0, 0));
        set_ld(4'd0, 4'd0, 4'd0, 4'd1);
        cyc(0, 0, 0, 0, 1, "ar_load", mk(16'h0001, 4'b0000, 0, 0, 0));
        cyc(0, 0, 1, 0, 0, "ar_start", mk(16'h0001, 4'b0000, 1, 0, 0));
        cyc(0, 1, 0, 0, 0, "ar_reload", mk(16'h0001, 4'b0001, 1, 1, 0));
        cyc(0, 0, 0, 0, 0, "ar_done_fall", mk(16'h0001, 4'b0000, 1, 0, 0));
        cyc(0, 1, 0, 0, 0, "ar_reload2", mk(16'h0001, 4'b0001, 1, 1, 0));
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_checks++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL %s: got t=%h upd=%b r/d/a=%b want t=%h upd=%b r/d/a=%b",
                         e.name, o[22:7], o[6:3], o[2:0], e.val[22:7], e.val[6:3], e.val[2:0]);
            end
        end
    endtask
`endif

    task automatic test_pause();
        exp_t        e;
        logic [22:0] o;
        cyc(1, 0, 0, 0, 0, "pa_rst", mk(16'h0000, 4'b0000, 0, 0, 0));
        set_ld(4'd0, 4'd0, 4'd4, 4'd5);
        cyc(0, 0, 0, 0, 1, "pa_load", mk(16'h0045, 4'b0000, 0, 0, 0));
        cyc(0, 0, 1, 0, 0, "pa_start", mk(16'h0045, 4'b0000, 1, 0, 0));
        cyc(0, 1, 0, 1, 0, "pa_pause_en", mk(16'h0045, 4'b0000, 0, 0, 0));
        cyc(0, 1, 0, 0, 0, "pa_en_paused", mk(16'h0045, 4'b0000, 0, 0, 0));
        cyc(0, 0, 1, 0, 0, "pa_resume", mk(16'h0045, 4'b0000, 1, 0, 0));
        cyc(0, 1, 0, 0, 0, "pa_dec", mk(16'h0044, 4'b0001, 1, 0, 0));
        // start together with en from IDLE: enters RUN without decrementing.
        cyc(1, 0, 0, 0, 0, "se_rst", mk(16'h0000, 4'b0000, 0, 0, 0));
        set_ld(4'd0, 4'd0, 4'd0, 4'd5);
        cyc(0, 0, 0, 0, 1, "se_load", mk(16'h0005, 4'b0000, 0, 0, 0));
        cyc(0, 1, 1, 0, 0, "se_start_en", mk(16'h0005, 4'b0000, 1, 0, 0));
        cyc(0, 1, 0, 0, 0, "se_dec", mk(16'h0004, 4'b0001, 1, 0, 0));
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_checks++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL %s: got t=%h upd=%b r/d/a=%b want t=%h upd=%b r/d/a=%b",
                         e.name, o[22:7], o[6:3], o[2:0], e.val[22:7], e.val[6:3], e.val[2:0]);
            end
        end
    endtask

    task automatic test_load_rules();
        exp_t        e;
        logic [22:0] o;
        cyc(1, 0, 0, 0, 0, "lc_rst", mk(16'h0000, 4'b0000, 0, 0, 0));
        set_ld(4'd7, 4'd9, 4'd9, 4'd9);
        cyc(0, 0, 0, 0, 1, "lc_clamp", mk(16'h5959, 4'b0000, 0, 0, 0));
        cyc(0, 0, 1, 0, 0, "lc_start", mk(16'h5959, 4'b0000, 1, 0, 0));
        set_ld(4'd1, 4'd1, 4'd1, 4'd1);
        cyc(0, 0, 0, 0, 1, "lc_load_in_run", mk(16'h5959, 4'b0000, 1, 0, 0));
        cyc(0, 0, 0, 1, 0, "lc_pause", mk(16'h5959, 4'b0000, 0, 0, 0));
        cyc(0, 0, 0, 0, 1, "lc_load_paused", mk(16'h1111, 4'b0000, 0, 0, 0));
        cyc(0, 1, 0, 0, 0, "lc_still_paused", mk(16'h1111, 4'b0000, 0, 0, 0));
        cyc(1, 0, 0, 0, 0, "sz_rst", mk(16'h0000, 4'b0000, 0, 0, 0));
        cyc(0, 0, 1, 0, 0, "sz_start_zero", mk(16'h0000, 4'b0000, 0, 0, 0));
        cyc(0, 1, 0, 0, 0, "sz_en_idle", mk(16'h0000, 4'b0000, 0, 0, 0));
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_checks++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL %s: got t=%h upd=%b r/d/a=%b want t=%h upd=%b r/d/a=%b",
                         e.name, o[22:7], o[6:3], o[2:0], e.val[22:7], e.val[6:3], e.val[2:0]);
            end
        end
    endtask

    task automatic test_rst_mid_run();
        exp_t        e;
        logic [22:0] o;
        cyc(1, 0, 0, 0, 0, "rm_rst", mk(16'h0000, 4'b0000, 0, 0, 0));
        set_ld(4'd0, 4'd3, 4'd1, 4'd7);
        cyc(0, 0, 0, 0, 1, "rm_load", mk(16'h0317, 4'b0000, 0, 0, 0));
        cyc(0, 0, 1, 0, 0, "rm_start", mk(16'h0317, 4'b0000, 1, 0, 0));
        cyc(0, 1, 0, 0, 0, "rm_dec", mk(16'h0316, 4'b0001, 1, 0, 0));
        cyc(1, 1, 0, 0, 1, "rm_reset", mk(16'h0000, 4'b0000, 0, 0, 0));
        cyc(0, 1, 0, 0, 0, "rm_after", mk(16'h0000, 4'b0000, 0, 0, 0));
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_checks++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL %s: got t=%h upd=%b r/d/a=%b want t=%h upd=%b r/d/a=%b",
                         e.name, o[22:7], o[6:3], o[2:0], e.val[22:7], e.val[6:3], e.val[2:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_units_borrow();
`ifndef COUNTDOWN_AUTORELOAD_EN
        test_expiry();
`else
        test_autoreload();
`endif
        test_pause();
        test_load_rules();
        test_rst_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
